bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NO_MASTERS, default 2, number of requesting masters.
REQ-002 Parameter NO_SLAVES, default 3, number of addressable slaves; slave IDs are 1..NO_SLAVES, and ID 0 means no slave.
REQ-003 Parameter S_ID_WIDTH, default $clog2(NO_SLAVES+1), slave-ID field width.
REQ-004 Parameter M_ID_WIDTH, default $clog2(NO_MASTERS), master-ID field width.
REQ-005 Parameter TIMEOUT, default 255, idle cycles tolerated during a grant before forced release; minimum 1.
REQ-006 clk  input  1  single clock; all state on the rising edge.
REQ-007 rstN  input  1  reset, asynchronous, active-low.
REQ-008 req_M[0:NO_MASTERS-1]  input  1 each  level bus request per master.
REQ-009 slave_id_M[0:NO_MASTERS-1]  input  S_ID_WIDTH each  target slave of each request.
REQ-010 done_M[0:NO_MASTERS-1]  input  1 each  one-cycle end-of-transaction pulse from each master.
REQ-011 valid_M[0:NO_MASTERS-1]  input  1 each  master data-valid, used only as activity for the watchdog.
REQ-012 ready  input  1  ready of the currently selected slave, as returned by the interconnect.
REQ-013 bus_state  output  S_ID_WIDTH+M_ID_WIDTH  {master_id, slave_id} select driven to the interconnect.
REQ-014 grant_M[0:NO_MASTERS-1]  output  1 each  one-hot ownership grant.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, GRANT and RELEASE; all outputs are registered.
REQ-018 A request is eligible only when req_M[m] is 1 and slave_id_M[m] is in the range 1..NO_SLAVES; other requests are ignored silently.
REQ-019 In IDLE, with at least one eligible request, the arbiter SHALL select by round-robin.
- Search starts at (last_master+1) mod NO_MASTERS.
- last_master resets to NO_MASTERS-1, so master 0 wins first after reset.
REQ-020 On selection, the next cycle SHALL enter SETUP with bus_state = {m, slave_id_M[m]} sampled at selection; the slave ID is latched and later changes are ignored.
REQ-021 In SETUP, grant_M SHALL stay all-zero until ready is 1; on the first cycle with ready=1, the next state is GRANT and grant_M[m] is 1.
- Minimum latency from request to grant is 2 cycles.
REQ-022 If req_M[m] drops during SETUP, the next state SHALL be RELEASE.
REQ-023 In GRANT, bus_state and grant_M SHALL be held constant; last_master is updated to m on entry.
REQ-024 GRANT SHALL exit to RELEASE on any of: done_M[m]=1, req_M[m]=0, or watchdog expiry.
REQ-025 Watchdog counter width is $clog2(TIMEOUT+1).
- Cleared on GRANT entry and on any cycle with valid_M[m]=1.
- Otherwise increments each GRANT cycle.
- Reaching TIMEOUT forces RELEASE and pulses timeout for exactly 1 cycle.
REQ-026 If done and timeout coincide, done SHALL take precedence and timeout SHALL not pulse.
REQ-027 RELEASE SHALL last exactly 1 cycle with grant_M all-zero and bus_state slave field 0 (master field held), then return to IDLE.
REQ-028 IDLE SHALL last at least 1 cycle, driving bus_state = 0 and grant_M = 0, so two grants are always separated by at least 2 ungranted cycles.
REQ-029 Inputs done_M, valid_M and req_M of non-selected masters SHALL have no effect on state.
REQ-030 grant_M SHALL never have more than one bit set, and a grant bit SHALL never be set while the bus_state slave field is 0.

Reset
REQ-031 When rstN is 0, the block SHALL immediately go to IDLE, regardless of operation in progress, with:
- bus_state = 0, grant_M = 0, busy = 0, timeout = 0;
- watchdog counter = 0;
- last_master = NO_MASTERS-1.
REQ-032 After rstN deasserts, the first arbitration decision SHALL occur on the first rising edge with rstN = 1.

Verification
REQ-033 Single request: M1 requests slave 2 with ready=1 -> bus_state = {1,2} at cycle +1, grant_M[1] = 1 at cycle +2, done pulse -> RELEASE then IDLE, bus_state = 0.
REQ-034 Contention: M0 and M1 request continuously, each pulsing done after 3 grant cycles -> grants alternate 0,1,0,1, each separated by the RELEASE and IDLE cycles.
REQ-035 Slave stall: ready = 0 for 5 cycles in SETUP -> no grant during the stall; grant occurs on the cycle after ready rises; bus_state is stable throughout.
REQ-036 Watchdog: TIMEOUT = 4, granted master holds valid = 0 -> timeout pulses once after 4 grant cycles and the grant is revoked; a variant with valid toggling every 3 cycles never times out.
REQ-037 Invalid and abort cases: slave_id = 0 or NO_SLAVES+1 -> never selected; req drops during SETUP -> RELEASE with no grant.
REQ-038 Reset mid-GRANT: rstN pulsed low -> all outputs are 0 asynchronously, before the next clock edge; after reset, master 0 wins the next contention.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the masters, the interconnect and the bus arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface bus_arbiter_if #(
    parameter int NO_MASTERS = 2,
    parameter int S_ID_WIDTH = 2,
    parameter int M_ID_WIDTH = 1
);
    logic [NO_MASTERS-1:0]            req_M;
    logic [S_ID_WIDTH-1:0]            slave_id_M [NO_MASTERS];
    logic [NO_MASTERS-1:0]            done_M;
    logic [NO_MASTERS-1:0]            valid_M;
    logic                             ready;
    logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state;
    logic [NO_MASTERS-1:0]            grant_M;
    logic                             busy;
    logic                             timeout;

    modport master (
        output req_M, slave_id_M, done_M, valid_M, ready,
        input  bus_state, grant_M, busy, timeout
    );

    modport slave (
        input  req_M, slave_id_M, done_M, valid_M, ready,
        output bus_state, grant_M, busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> SETUP -> GRANT -> RELEASE, with a per-grant
// inactivity watchdog. All outputs come straight from registers.
module bus_arbiter #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS),
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rstN,
    bus_arbiter_if.slave   bus
);
    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} state_t;

    state_t                           state_reg;
    logic [M_ID_WIDTH-1:0]            sel_reg;
    logic [M_ID_WIDTH-1:0]            last_master_reg;
    logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state_reg;
    logic [NO_MASTERS-1:0]            grant_reg;
    logic                             busy_reg;
    logic                             timeout_reg;
    logic [WD_WIDTH-1:0]              wdog_reg;

    logic [NO_MASTERS-1:0] eligible;
    logic [NO_MASTERS-1:0] shifted;
    logic [M_ID_WIDTH-1:0] pick_hi, pick_lo, pick;
    logic                  found_hi, found_lo;
    logic                  sel_req, sel_done, sel_valid, wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NO_MASTERS; gi++) begin : g_elig
            assign eligible[gi] = bus.req_M[gi]
                               && (bus.slave_id_M[gi] != '0)
                               && (bus.slave_id_M[gi] <= S_ID_WIDTH'(NO_SLAVES));
        end
    endgenerate

    // Descending scan leaves the lowest matching index; the "hi" pick only
    // considers masters after last_master, giving the round-robin wrap.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        shifted  = '0;
        for (int j = NO_MASTERS - 1; j >= 0; j--) begin
            shifted = eligible >> j;
            if (shifted[0]) begin
                found_lo = 1'b1;
                pick_lo  = M_ID_WIDTH'(j);
                if (j > int'(last_master_reg)) begin
                    found_hi = 1'b1;
                    pick_hi  = M_ID_WIDTH'(j);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign sel_req    = bus.req_M[sel_reg];
    assign sel_done   = bus.done_M[sel_reg];
    assign sel_valid  = bus.valid_M[sel_reg];
    assign wd_expired = !sel_valid && (wdog_reg == WD_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            last_master_reg <= M_ID_WIDTH'(NO_MASTERS - 1);
            bus_state_reg   <= '0;
            grant_reg       <= '0;
            busy_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            wdog_reg        <= '0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (found_lo) begin
                        state_reg     <= SETUP;
                        sel_reg       <= pick;
                        bus_state_reg <= {pick, bus.slave_id_M[pick]};
                        busy_reg      <= 1'b1;
                    end
                end
                SETUP: begin
                    // A withdrawn request wins over a slave that just became ready.
                    if (!sel_req) begin
                        state_reg                     <= RELEASE;
                        bus_state_reg[S_ID_WIDTH-1:0] <= '0;
                    end else if (bus.ready) begin
                        state_reg       <= GRANT;
                        grant_reg       <= NO_MASTERS'(1) << sel_reg;
                        last_master_reg <= sel_reg;
                        wdog_reg        <= '0;
                    end
                end
                GRANT: begin
                    if (sel_done || !sel_req || wd_expired) begin
                        state_reg                     <= RELEASE;
                        grant_reg                     <= '0;
                        bus_state_reg[S_ID_WIDTH-1:0] <= '0;
                        timeout_reg                   <= wd_expired && !sel_done;
                        wdog_reg                      <= '0;
                    end else if (sel_valid) begin
                        wdog_reg <= '0;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    state_reg     <= IDLE;
                    bus_state_reg <= '0;
                    busy_reg      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.bus_state = bus_state_reg;
    assign bus.grant_M   = grant_reg;
    assign bus.busy      = busy_reg;
    assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 2 masters, 2 slaves, TIMEOUT = 4.
// bus_state is {master(1), slave(2)}; outputs sampled 1 time unit after the edge.
module tb_bus_arbiter;
    logic clk;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if #(.NO_MASTERS(2), .S_ID_WIDTH(2), .M_ID_WIDTH(1)) intf ();

    bus_arbiter #(
        .NO_MASTERS(2),
        .NO_SLAVES (2),
        .TIMEOUT   (4)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        intf.req_M         = 2'b00;
        intf.done_M        = 2'b00;
        intf.valid_M       = 2'b00;
        intf.slave_id_M[0] = 2'd0;
        intf.slave_id_M[1] = 2'd0;
        intf.ready         = 1'b0;
    endtask

    initial begin
        logic [0:0] m;
        rstN = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_bus_state", 32'(intf.bus_state), 32'h0);
        check("rst_grant",     32'(intf.grant_M),   32'h0);
        check("rst_busy",      32'(intf.busy),      32'h0);
        check("rst_timeout",   32'(intf.timeout),   32'h0);
        rstN = 1'b1;

        // Single request: M1 -> slave 2
        intf.ready = 1'b1;
        intf.valid_M = 2'b11;
        intf.req_M[1] = 1'b1;
        intf.slave_id_M[1] = 2'd2;
        tick();
        check("single_setup_bs",   32'(intf.bus_state), 32'h6);
        check("single_setup_gnt",  32'(intf.grant_M),   32'h0);
        check("single_setup_busy", 32'(intf.busy),      32'h1);
        tick();
        check("single_grant",      32'(intf.grant_M),   32'h2);
        check("single_grant_bs",   32'(intf.bus_state), 32'h6);
        intf.done_M[1] = 1'b1;
        tick();
        check("single_rel_gnt",    32'(intf.grant_M),   32'h0);
        check("single_rel_bs",     32'(intf.bus_state), 32'h4);
        check("single_rel_busy",   32'(intf.busy),      32'h1);
        intf.done_M[1] = 1'b0;
        intf.req_M[1] = 1'b0;
        tick();
        check("single_idle_bs",    32'(intf.bus_state), 32'h0);
        check("single_idle_busy",  32'(intf.busy),      32'h0);

        // Contention: last master is 1, so grants go 0,1,0,1
        intf.req_M = 2'b11;
        intf.slave_id_M[0] = 2'd1;
        intf.slave_id_M[1] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            m = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check("cont_setup_bs", 32'(intf.bus_state), (m == 1'b0) ? 32'h1 : 32'h6);
            for (int c = 0; c < 3; c++) begin
                tick();
                check("cont_grant", 32'(intf.grant_M), (m == 1'b0) ? 32'h1 : 32'h2);
            end
            intf.done_M[m] = 1'b1;
            tick();
            check("cont_rel_gnt", 32'(intf.grant_M), 32'h0);
            intf.done_M[m] = 1'b0;
            tick();
            check("cont_idle_busy", 32'(intf.busy), 32'h0);
        end
        intf.req_M = 2'b00;
        tick();

        // Slave stall: ready low for 5 SETUP cycles
        intf.ready = 1'b0;
        intf.req_M[0] = 1'b1;
        intf.slave_id_M[0] = 2'd2;
        tick();
        check("stall_setup_bs", 32'(intf.bus_state), 32'h2);
        for (int s = 0; s < 4; s++) begin
            tick();
            check("stall_no_grant", 32'(intf.grant_M),   32'h0);
            check("stall_bs",       32'(intf.bus_state), 32'h2);
        end
        intf.ready = 1'b1;
        tick();
        check("stall_grant",    32'(intf.grant_M),   32'h1);
        check("stall_grant_bs", 32'(intf.bus_state), 32'h2);
        intf.req_M[0] = 1'b0;
        tick();
        check("stall_rel_gnt",  32'(intf.grant_M),   32'h0);
        check("stall_rel_to",   32'(intf.timeout),   32'h0);
        tick();

        // Watchdog: M1 idle for 4 grant cycles
        intf.valid_M = 2'b00;
        intf.req_M[1] = 1'b1;
        intf.slave_id_M[1] = 2'd1;
        tick();
        tick();
        check("wd_grant_c1", 32'(intf.grant_M), 32'h2);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("wd_grant_held", 32'(intf.grant_M), 32'h2);
            check("wd_no_timeout", 32'(intf.timeout), 32'h0);
        end
        tick();
        check("wd_timeout_pulse", 32'(intf.timeout), 32'h1);
        check("wd_revoked",       32'(intf.grant_M), 32'h0);
        intf.req_M[1] = 1'b0;
        tick();
        check("wd_timeout_clear", 32'(intf.timeout), 32'h0);

        // Watchdog variant: valid every third cycle keeps the grant alive
        intf.req_M[1] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            intf.valid_M[1] = (i % 3 == 2);
            tick();
            check("wdv_grant",   32'(intf.grant_M), 32'h2);
            check("wdv_no_to",   32'(intf.timeout), 32'h0);
        end
        intf.valid_M[1] = 1'b0;
        intf.done_M[1] = 1'b1;
        tick();
        check("wdv_rel_gnt", 32'(intf.grant_M), 32'h0);
        check("wdv_rel_to",  32'(intf.timeout), 32'h0);
        intf.done_M[1] = 1'b0;
        tick();

        // done coinciding with watchdog expiry suppresses the timeout pulse
        tick();
        tick();
        tick();
        tick();
        tick();
        check("coinc_grant_c4", 32'(intf.grant_M), 32'h2);
        intf.done_M[1] = 1'b1;
        tick();
        check("coinc_rel_gnt", 32'(intf.grant_M), 32'h0);
        check("coinc_no_to",   32'(intf.timeout), 32'h0);
        intf.done_M[1] = 1'b0;
        intf.req_M[1] = 1'b0;
        tick();

        // Invalid slave IDs are never selected
        intf.valid_M = 2'b11;
        intf.req_M = 2'b11;
        intf.slave_id_M[0] = 2'd0;
        intf.slave_id_M[1] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("inv_busy", 32'(intf.busy),      32'h0);
            check("inv_bs",   32'(intf.bus_state), 32'h0);
        end

        // Abort in SETUP; slave id latched at selection
        intf.ready = 1'b0;
        intf.req_M = 2'b01;
        intf.slave_id_M[0] = 2'd1;
        tick();
        check("abort_setup_bs", 32'(intf.bus_state), 32'h1);
        intf.slave_id_M[0] = 2'd2;
        tick();
        check("abort_latched_bs", 32'(intf.bus_state), 32'h1);
        intf.req_M[0] = 1'b0;
        tick();
        check("abort_rel_busy", 32'(intf.busy),      32'h1);
        check("abort_rel_gnt",  32'(intf.grant_M),   32'h0);
        check("abort_rel_bs",   32'(intf.bus_state), 32'h0);
        tick();
        check("abort_idle_busy", 32'(intf.busy), 32'h0);

        // Reset mid-GRANT: asynchronous clear, then master 0 wins again
        intf.ready = 1'b1;
        intf.req_M[0] = 1'b1;
        intf.slave_id_M[0] = 2'd1;
        tick();
        tick();
        check("prerst_grant", 32'(intf.grant_M), 32'h1);
        #2;
        rstN = 1'b0;
        #1;
        check("async_rst_gnt",  32'(intf.grant_M),   32'h0);
        check("async_rst_bs",   32'(intf.bus_state), 32'h0);
        check("async_rst_busy", 32'(intf.busy),      32'h0);
        rstN = 1'b1;
        intf.req_M = 2'b11;
        intf.slave_id_M[1] = 2'd2;
        tick();
        check("postrst_winner_bs", 32'(intf.bus_state), 32'h1);
        tick();
        check("postrst_grant", 32'(intf.grant_M), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
